// File: rtl/depth_test_unit.sv
`default_nettype none
// ============================================================================
//  Module   : depth_test_unit
//  Purpose  : Per-fragment Z-buffer test. Accepts one fragment at a time from
//             the rasterizer and reads the stored depth. It compares the
//             fragment depth against the stored depth using the latched depth
//             function. On a pass it writes both the depth word and the
//             RGB565 color to the framebuffer ports.
//  Config   : CELERY_DEPTH_TEST_EN
//               defined   -> full read / compare / write flow.
//               undefined -> depth test removed. Every accepted fragment goes
//                            straight to a color write, the depth port stays
//                            idle, fail_cnt stays 0 and depth_func is ignored.
//  Ports    : clk, rst_n (asynchronous, active-low)
//             frag_valid/frag_ready, frag_x/y/z/color, depth_func : fragment in
//             z_req/z_we/z_addr/z_wdata/z_gnt/z_rvalid/z_rdata    : depth port
//             c_valid/c_addr/c_data/c_ready                       : color port
//             pass_cnt, fail_cnt, busy                            : status
//  Revision : 1.0  initial release
// ============================================================================
module depth_test_unit #(
    parameter int SCREEN_W = 640,
    parameter int ADDR_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frag_valid,
    output logic              frag_ready,
    input  logic [9:0]        frag_x,
    input  logic [9:0]        frag_y,
    input  logic [31:0]       frag_z,
    input  logic [15:0]       frag_color,
    input  logic [1:0]        depth_func,
    output logic              z_req,
    output logic              z_we,
    output logic [ADDR_W-1:0] z_addr,
    output logic [31:0]       z_wdata,
    input  logic              z_gnt,
    input  logic              z_rvalid,
    input  logic [31:0]       z_rdata,
    output logic              c_valid,
    output logic [ADDR_W-1:0] c_addr,
    output logic [15:0]       c_data,
    input  logic              c_ready,
    output logic [31:0]       pass_cnt,
    output logic [31:0]       fail_cnt,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        COMPARE = 3'd3,
        WRITE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_z;
    logic [15:0]       r_color;
    logic              r_cdone;
    logic [31:0]       r_pass_cnt;
    logic [31:0]       r_fail_cnt;

    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic              w_c_hs;
    logic              w_z_side_done;
    logic              w_write_done;

    assign w_accept = frag_valid && (r_state == IDLE);

    // Row-major framebuffer address. All terms are sized to ADDR_W, so the
    // arithmetic wraps modulo 2^ADDR_W, which is the required truncation.
    assign w_addr = ADDR_W'(frag_y) * ADDR_W'(SCREEN_W) + ADDR_W'(frag_x);

    // Color side of the WRITE phase, common to both builds.
    assign c_valid      = (r_state == WRITE) && !r_cdone;
    assign w_c_hs       = c_valid && c_ready;
    assign w_write_done = (r_state == WRITE) && w_z_side_done && (r_cdone || w_c_hs);

`ifdef CELERY_DEPTH_TEST_EN
    logic [31:0] r_old;
    logic [1:0]  r_func;
    logic        r_zdone;
    logic        w_pass;
    logic        w_z_hs;

    // A single request line serves both phases: a read in RD_REQ and a
    // write in WRITE. The write half drops once its grant has been seen.
    assign z_req         = (r_state == RD_REQ) || ((r_state == WRITE) && !r_zdone);
    assign z_we          = (r_state == WRITE) && !r_zdone;
    assign w_z_hs        = z_req && z_gnt;
    assign w_z_side_done = r_zdone || w_z_hs;

    // Depth values are non-negative after the clamp, so an unsigned
    // integer compare orders them the same way as a float compare.
    always_comb begin
        w_pass = 1'b0;
        case (r_func)
            2'b00:   w_pass = (r_z <  r_old);
            2'b01:   w_pass = (r_z <= r_old);
            2'b10:   w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_old   <= '0;
            r_func  <= '0;
            r_zdone <= 1'b0;
        end else begin
            if (w_accept) begin
                r_func <= depth_func;
            end
            // A z_rvalid that coincides with the read grant is still seen in
            // RD_REQ and is ignored; only RD_WAIT captures data.
            if ((r_state == RD_WAIT) && z_rvalid) begin
                r_old <= z_rdata;
            end
            if ((r_state == WRITE) && !w_write_done) begin
                if (w_z_hs) begin
                    r_zdone <= 1'b1;
                end
            end else begin
                r_zdone <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
        end else if ((r_state == COMPARE) && !w_pass) begin
            r_fail_cnt <= r_fail_cnt + 32'd1;
        end
    end
`else
    // The depth port is unused in this build.
    logic w_unused_depth_port;
    assign w_unused_depth_port = ^{z_gnt, z_rvalid, z_rdata, depth_func};

    assign z_req         = 1'b0;
    assign z_we          = 1'b0;
    assign w_z_side_done = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
        end else begin
            r_fail_cnt <= '0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
`ifdef CELERY_DEPTH_TEST_EN
                    w_state_nxt = RD_REQ;
`else
                    w_state_nxt = WRITE;
`endif
                end
            end
`ifdef CELERY_DEPTH_TEST_EN
            RD_REQ: begin
                if (z_gnt) begin
                    w_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (z_rvalid) begin
                    w_state_nxt = COMPARE;
                end
            end
            COMPARE: begin
                w_state_nxt = w_pass ? WRITE : IDLE;
            end
`endif
            WRITE: begin
                if (w_write_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Fragment latch, color handshake tracking and pass counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_z     <= '0;
            r_color <= '0;
            r_cdone <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= w_addr;
                // Negative depths are clamped to +0.0 at capture time.
                r_z     <= frag_z[31] ? 32'd0 : frag_z;
                r_color <= frag_color;
            end
            // The color done flag lets the two ports finish in any order.
            // It clears when WRITE completes or is not active.
            if ((r_state == WRITE) && !w_write_done) begin
                if (w_c_hs) begin
                    r_cdone <= 1'b1;
                end
            end else begin
                r_cdone <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass_cnt <= '0;
        end else if (w_write_done) begin
            r_pass_cnt <= r_pass_cnt + 32'd1;
        end
    end

    assign frag_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign z_addr     = r_addr;
    assign c_addr     = r_addr;
    assign z_wdata    = r_z;
    assign c_data     = r_color;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_depth_test_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_depth_test_unit
//  Purpose  : Self-checking bench for depth_test_unit. It runs a directed
//             table, randomized fragments against a reference model, and a
//             reset-while-in-flight sequence. The bench itself acts as the
//             depth and color memories, with programmable handshake delays.
//  Revision : 1.0  initial release
// ============================================================================
module tb_depth_test_unit;

    localparam int SCREEN_W = 640;
    localparam int ADDR_W   = 19;
`ifdef CELERY_DEPTH_TEST_EN
    localparam bit DEPTH_EN = 1'b1;
`else
    localparam bit DEPTH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frag_valid = 1'b0;
    logic              frag_ready;
    logic [9:0]        frag_x = '0;
    logic [9:0]        frag_y = '0;
    logic [31:0]       frag_z = '0;
    logic [15:0]       frag_color = '0;
    logic [1:0]        depth_func = '0;
    logic              z_req, z_we;
    logic [ADDR_W-1:0] z_addr;
    logic [31:0]       z_wdata;
    logic              z_gnt = 1'b0;
    logic              z_rvalid = 1'b0;
    logic [31:0]       z_rdata = '0;
    logic              c_valid;
    logic [ADDR_W-1:0] c_addr;
    logic [15:0]       c_data;
    logic              c_ready = 1'b0;
    logic [31:0]       pass_cnt, fail_cnt;
    logic              busy;

    always #5 clk = ~clk;

    depth_test_unit #(.SCREEN_W(SCREEN_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .frag_valid(frag_valid), .frag_ready(frag_ready),
        .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z),
        .frag_color(frag_color), .depth_func(depth_func),
        .z_req(z_req), .z_we(z_we), .z_addr(z_addr), .z_wdata(z_wdata),
        .z_gnt(z_gnt), .z_rvalid(z_rvalid), .z_rdata(z_rdata),
        .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
    );

    typedef struct {
        int          x, y;
        logic [31:0] z;
        logic [15:0] col;
        logic [1:0]  func;
        logic [31:0] stored;
        int          gd, rd, cd;   // grant, read-data and c_ready delays
        bit          noise;        // bogus z_rvalid alongside read grant
        int          exp_addr;
        bit          exp_pass;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        int          reads, zwrites, cwrites;
        int          zrq_rd, zrq_wr, cv, busy_cyc;
        logic [31:0] raddr, wdata, caddr;
        logic [15:0] cdata;
        bit          ready_ok, timeout;
    } obs_t;

    int n_checks = 0;
    int n_pass   = 0;
    int m_pass   = 0;
    int m_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] clamp(input logic [31:0] z);
        return z[31] ? 32'd0 : z;
    endfunction

    function automatic bit model_pass(input logic [1:0] f, input logic [31:0] z,
                                      input logic [31:0] old);
        longint a, b;
        a = longint'(clamp(z));
        b = longint'(old);
        case (f)
            2'd0:    return a < b;
            2'd1:    return a <= b;
            2'd2:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_addr(input int x, input int y);
        return (y * SCREEN_W + x) % (1 << ADDR_W);
    endfunction

    function automatic vec_t mk(input int x, input int y, input logic [31:0] z,
                                input logic [15:0] col, input logic [1:0] f,
                                input logic [31:0] st, input int gd, input int rd,
                                input int cd, input bit nz, input int ea,
                                input bit ep, input logic [31:0] ew);
        vec_t v;
        v.x = x; v.y = y; v.z = z; v.col = col; v.func = f; v.stored = st;
        v.gd = gd; v.rd = rd; v.cd = cd; v.noise = nz;
        v.exp_addr = ea; v.exp_pass = ep; v.exp_wdata = ew;
        return v;
    endfunction

    // Offer one fragment and act as both memories until the unit is idle.
    // Called and returns at a falling edge.
    task automatic run_frag(input vec_t v, output obs_t o);
        int zw, rvc, cw;
        bit pend;
        zw = 0; rvc = 0; cw = 0; pend = 1'b0;
        o.reads = 0; o.zwrites = 0; o.cwrites = 0; o.zrq_rd = 0; o.zrq_wr = 0;
        o.cv = 0; o.busy_cyc = 0; o.raddr = '0; o.wdata = '0; o.caddr = '0;
        o.cdata = '0; o.timeout = 1'b1;
        o.ready_ok = frag_ready;
        frag_valid = 1'b1;
        frag_x = 10'(v.x); frag_y = 10'(v.y); frag_z = v.z;
        frag_color = v.col; depth_func = v.func;
        @(negedge clk);
        frag_valid = 1'b0;
        // Scramble the inputs so that a unit which fails to latch them is caught.
        frag_x = 10'($urandom); frag_y = 10'($urandom); frag_z = $urandom;
        frag_color = 16'($urandom); depth_func = 2'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            z_gnt = 1'b0; z_rvalid = 1'b0; c_ready = 1'b0; z_rdata = $urandom;
            if (!busy) begin
                o.timeout = 1'b0;
                break;
            end
            o.busy_cyc++;
            if (pend) begin
                if (rvc >= v.rd) begin
                    z_rvalid = 1'b1; z_rdata = v.stored; pend = 1'b0;
                end else begin
                    rvc++;
                end
            end
            if (z_req) begin
                if (z_we) o.zrq_wr++; else o.zrq_rd++;
                if (zw >= v.gd) begin
                    z_gnt = 1'b1; zw = 0;
                    if (!z_we) begin
                        o.reads++; o.raddr = 32'(z_addr); pend = 1'b1; rvc = 0;
                        if (v.noise) begin
                            z_rvalid = 1'b1; z_rdata = ~v.stored;
                        end
                    end else begin
                        o.zwrites++; o.wdata = z_wdata;
                    end
                end else begin
                    zw++;
                end
            end
            if (c_valid) begin
                o.cv++;
                if (cw >= v.cd) begin
                    c_ready = 1'b1; o.cwrites++; o.cdata = c_data;
                    o.caddr = 32'(c_addr); cw = 0;
                end else begin
                    cw++;
                end
            end
            @(negedge clk);
        end
        z_gnt = 1'b0; z_rvalid = 1'b0; c_ready = 1'b0;
    endtask

    task automatic check_frag(input string tag, input vec_t v, input obs_t o);
        bit p, wr;
        int wcyc;
        p    = DEPTH_EN ? v.exp_pass : 1'b1;
        wr   = DEPTH_EN && p;
        wcyc = ((v.gd > v.cd) ? v.gd : v.cd) + 1;
        m_pass += p ? 1 : 0;
        m_fail += (DEPTH_EN && !p) ? 1 : 0;
        check({tag, "_ready"},   o.ready_ok, 1);
        check({tag, "_timeout"}, o.timeout, 0);
        check({tag, "_reads"},   o.reads, DEPTH_EN ? 1 : 0);
        check({tag, "_raddr"},   o.raddr, DEPTH_EN ? v.exp_addr : 0);
        check({tag, "_zrq_rd"},  o.zrq_rd, DEPTH_EN ? v.gd + 1 : 0);
        check({tag, "_zwrites"}, o.zwrites, wr ? 1 : 0);
        check({tag, "_wdata"},   o.wdata, wr ? v.exp_wdata : 32'd0);
        check({tag, "_zrq_wr"},  o.zrq_wr, wr ? v.gd + 1 : 0);
        check({tag, "_cwrites"}, o.cwrites, p ? 1 : 0);
        check({tag, "_cdata"},   o.cdata, p ? v.col : 16'd0);
        check({tag, "_caddr"},   o.caddr, p ? v.exp_addr : 0);
        check({tag, "_cv_cyc"},  o.cv, p ? v.cd + 1 : 0);
        check({tag, "_busy_cyc"}, o.busy_cyc,
              DEPTH_EN ? (v.gd + 1) + (v.rd + 1) + 1 + (p ? wcyc : 0) : v.cd + 1);
        check({tag, "_pass_cnt"}, pass_cnt, m_pass);
        check({tag, "_fail_cnt"}, fail_cnt, m_fail);
    endtask

    vec_t tbl[11];
    vec_t v;
    obs_t o;

    initial begin
        tbl[0]  = mk(3, 2, 32'h3F000000, 16'hF800, 2'd0, 32'h3F400000, 0, 0, 0, 0, 1283, 1, 32'h3F000000);
        tbl[1]  = mk(3, 2, 32'h3F000000, 16'h07E0, 2'd0, 32'h3F000000, 0, 0, 0, 0, 1283, 0, 32'h3F000000);
        tbl[2]  = mk(3, 2, 32'h3F000000, 16'h07E0, 2'd1, 32'h3F000000, 0, 0, 0, 0, 1283, 1, 32'h3F000000);
        tbl[3]  = mk(5, 0, 32'hBF800000, 16'h001F, 2'd2, 32'h12345678, 1, 1, 1, 0, 5, 1, 32'h00000000);
        tbl[4]  = mk(7, 7, 32'h00000000, 16'hFFFF, 2'd3, 32'hFFFFFFFF, 0, 0, 0, 0, 4487, 0, 32'h00000000);
        tbl[5]  = mk(100, 50, 32'hBF800000, 16'h1234, 2'd0, 32'h00000001, 0, 2, 0, 1, 32100, 1, 32'h00000000);
        tbl[6]  = mk(10, 20, 32'h3E800000, 16'hABCD, 2'd0, 32'h3F800000, 0, 0, 5, 0, 12810, 1, 32'h3E800000);
        tbl[7]  = mk(1023, 1023, 32'h40000000, 16'h5555, 2'd1, 32'h3F800000, 1, 0, 0, 0, 131455, 0, 32'h40000000);
        tbl[8]  = mk(639, 479, 32'h00000001, 16'hAAAA, 2'd0, 32'h00000002, 3, 4, 0, 1, 307199, 1, 32'h00000001);
        tbl[9]  = mk(0, 0, 32'h7F800000, 16'h0F0F, 2'd0, 32'hFFFFFFFF, 2, 1, 2, 1, 0, 1, 32'h7F800000);
        tbl[10] = mk(320, 240, 32'h3F000000, 16'hF0F0, 2'd2, 32'h00000000, 0, 0, 3, 0, 153920, 1, 32'h3F000000);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_frag_ready", frag_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_z_req", z_req, 0);
        check("rst_z_we", z_we, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_z_addr", z_addr, 0);
        check("rst_z_wdata", z_wdata, 0);
        check("rst_c_data", c_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_frag(tbl[i], o);
            check_frag($sformatf("vec%0d", i), tbl[i], o);
        end

        // Randomized fragments against the model
        for (int i = 0; i < 30; i++) begin
            logic [31:0] zz;
            zz = $urandom;
            v.x = $urandom_range(0, 1023);
            v.y = $urandom_range(0, 1023);
            v.z = zz;
            v.col = 16'($urandom);
            v.func = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       v.stored = clamp(zz);
                1:       v.stored = clamp(zz) + 32'd1;
                default: v.stored = $urandom;
            endcase
            v.gd = $urandom_range(0, 3);
            v.rd = $urandom_range(0, 3);
            v.cd = $urandom_range(0, 3);
            v.noise = 1'($urandom);
            v.exp_addr = model_addr(v.x, v.y);
            v.exp_pass = model_pass(v.func, v.z, v.stored);
            v.exp_wdata = clamp(v.z);
            run_frag(v, o);
            check_frag($sformatf("rnd%0d", i), v, o);
        end

        // Reset while a fragment is in flight
        frag_valid = 1'b1; frag_x = 10'd10; frag_y = 10'd1;
        frag_z = 32'h00000005; frag_color = 16'hBEEF; depth_func = 2'd2;
        @(negedge clk);
        frag_valid = 1'b0;
`ifdef CELERY_DEPTH_TEST_EN
        check("inflt_rd_req", z_req, 1);
        z_gnt = 1'b1;
        @(negedge clk);
        z_gnt = 1'b0;
        check("inflt_rd_wait_req", z_req, 0);
        check("inflt_rd_wait_busy", busy, 1);
`else
        check("inflt_c_valid", c_valid, 1);
`endif
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("inrst_z_req", z_req, 0);
        check("inrst_c_valid", c_valid, 0);
        check("inrst_busy", busy, 0);
        check("inrst_pass_cnt", pass_cnt, 0);
        check("inrst_fail_cnt", fail_cnt, 0);
        check("inrst_z_wdata", z_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", frag_ready, 1);
        check("postrst_z_req", z_req, 0);
        check("postrst_c_valid", c_valid, 0);
        m_pass = 0;
        m_fail = 0;
        v = mk(4, 3, 32'h3F000000, 16'h1357, 2'd0, 32'h3F800000, 0, 0, 0, 0, 1924, 1, 32'h3F000000);
        run_frag(v, o);
        check_frag("postrst", v, o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
